// File: rtl/action_exec.sv
// action_exec: applies one resolved action record per packet to the matching
// AXI4-Stream packet (forward with tdest, drop, trap pulse to the PS).
// Latency: action accepted at N -> first beat accepted >= N+1; beat accepted at M -> on m_* at M+1.
// Backpressure: one registered output stage; s_tready = !m_tvalid || m_tready while forwarding,
//               always 1 while dropping, 0 while idle (waiting for an action).
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   act_valid/act_ready + act_*   action record handshake (hit, drop, forward, out_port, trap, flow_id)
//   s_t*                          input AXI4-Stream (tdata, tkeep, tlast, tvalid/tready)
//   m_t*                          output AXI4-Stream (tdata, tkeep, tlast, tdest, tvalid/tready)
//   trap_valid, trap_flow_id      one-cycle trap pulse; flow id held until the next trap
// Optional: define ACTION_EXEC_STATS_EN to add 32-bit wrapping fwd_cnt, drop_cnt, trap_cnt outputs.

module action_exec #(
   parameter int                DATA_W    = 64,
   parameter int                PORT_W    = 4,
   parameter bit                MISS_FWD  = 1'b0,
   parameter logic [PORT_W-1:0] MISS_PORT = '0
) (
   input  logic                  clk,
   input  logic                  rst,

   input  logic                  act_valid,
   output logic                  act_ready,
   input  logic                  act_hit,
   input  logic                  act_drop,
   input  logic                  act_forward,
   input  logic [PORT_W-1:0]     act_out_port,
   input  logic                  act_trap,
   input  logic [15:0]           act_flow_id,

   input  logic [DATA_W-1:0]     s_tdata,
   input  logic [DATA_W/8-1:0]   s_tkeep,
   input  logic                  s_tlast,
   input  logic                  s_tvalid,
   output logic                  s_tready,

   output logic [DATA_W-1:0]     m_tdata,
   output logic [DATA_W/8-1:0]   m_tkeep,
   output logic                  m_tlast,
   output logic [PORT_W-1:0]     m_tdest,
   output logic                  m_tvalid,
   input  logic                  m_tready,

   output logic                  trap_valid,
   output logic [15:0]           trap_flow_id
`ifdef ACTION_EXEC_STATS_EN
   ,
   output logic [31:0]           fwd_cnt,
   output logic [31:0]           drop_cnt,
   output logic [31:0]           trap_cnt
`endif
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FWD  = 2'd1,
      DROP = 2'd2
   } state_t;

   state_t            state;
   logic [PORT_W-1:0] pkt_dest;   // tdest for every beat of the current packet
   logic              act_fire;
   logic              beat_fire;
   logic              go_fwd;
   logic [PORT_W-1:0] act_dest;

   // Gated by rst so the record is never taken while reset is held.
   assign act_ready = (state == IDLE) && !rst;
   assign act_fire  = act_valid && act_ready;
   assign beat_fire = s_tvalid && s_tready;

   always_comb begin
      s_tready = 1'b0;
      case (state)
         FWD:     s_tready = !m_tvalid || m_tready;
         DROP:    s_tready = 1'b1;
         default: s_tready = 1'b0;
      endcase
   end

   // Decision for the record at the head of the action stream.
   // Drop wins over forward; a miss follows the MISS_FWD policy.
   always_comb begin
      go_fwd   = MISS_FWD;
      act_dest = MISS_PORT;
      if (act_hit) begin
         go_fwd   = !act_drop && act_forward;
         act_dest = act_out_port;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         pkt_dest     <= '0;
         m_tdata      <= '0;
         m_tkeep      <= '0;
         m_tlast      <= 1'b0;
         m_tdest      <= '0;
         m_tvalid     <= 1'b0;
         trap_valid   <= 1'b0;
         trap_flow_id <= '0;
      end else begin
         trap_valid <= 1'b0;

         // Output register drains independently of state: the last beat of a
         // packet may still be waiting on m_tready after we are back in IDLE.
         if (m_tvalid && m_tready)
            m_tvalid <= 1'b0;

         case (state)
            IDLE: begin
               if (act_fire) begin
                  state    <= go_fwd ? FWD : DROP;
                  pkt_dest <= act_dest;
                  if (act_hit && act_trap) begin
                     trap_valid   <= 1'b1;
                     trap_flow_id <= act_flow_id;
                  end
               end
            end

            FWD: begin
               if (beat_fire) begin
                  m_tdata  <= s_tdata;
                  m_tkeep  <= s_tkeep;
                  m_tlast  <= s_tlast;
                  m_tdest  <= pkt_dest;
                  m_tvalid <= 1'b1;
                  if (s_tlast)
                     state <= IDLE;
               end
            end

            DROP: begin
               if (beat_fire && s_tlast)
                  state <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end

`ifdef ACTION_EXEC_STATS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fwd_cnt  <= '0;
         drop_cnt <= '0;
         trap_cnt <= '0;
      end else begin
         if (state == FWD && beat_fire && s_tlast)
            fwd_cnt <= fwd_cnt + 32'd1;
         if (state == DROP && beat_fire && s_tlast)
            drop_cnt <= drop_cnt + 32'd1;
         if (trap_valid)
            trap_cnt <= trap_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_action_exec.sv
// tb_action_exec: directed self-checking bench for action_exec.
// A cycle engine drives queued actions and beats, logs handshakes and output beats;
// each test task compares the log against hand-computed expectations.

module tb_action_exec;

   logic        clk = 1'b0;
   logic        rst;
   logic        act_valid, act_ready, act_hit, act_drop, act_forward, act_trap;
   logic [3:0]  act_out_port;
   logic [15:0] act_flow_id;
   logic [63:0] s_tdata;
   logic [7:0]  s_tkeep;
   logic        s_tlast, s_tvalid, s_tready;
   logic [63:0] m_tdata;
   logic [7:0]  m_tkeep;
   logic        m_tlast, m_tvalid, m_tready;
   logic [3:0]  m_tdest;
   logic        trap_valid;
   logic [15:0] trap_flow_id;
`ifdef ACTION_EXEC_STATS_EN
   logic [31:0] fwd_cnt, drop_cnt, trap_cnt;
`endif

   always #5 clk = ~clk;

   action_exec #(
      .DATA_W(64), .PORT_W(4), .MISS_FWD(1'b0), .MISS_PORT(4'd0)
   ) dut (
      .clk(clk), .rst(rst),
      .act_valid(act_valid), .act_ready(act_ready), .act_hit(act_hit),
      .act_drop(act_drop), .act_forward(act_forward), .act_out_port(act_out_port),
      .act_trap(act_trap), .act_flow_id(act_flow_id),
      .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tlast(s_tlast),
      .s_tvalid(s_tvalid), .s_tready(s_tready),
      .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tlast(m_tlast), .m_tdest(m_tdest),
      .m_tvalid(m_tvalid), .m_tready(m_tready),
      .trap_valid(trap_valid), .trap_flow_id(trap_flow_id)
`ifdef ACTION_EXEC_STATS_EN
      , .fwd_cnt(fwd_cnt), .drop_cnt(drop_cnt), .trap_cnt(trap_cnt)
`endif
   );

   typedef struct packed {
      logic        hit, drop, fwd, trap;
      logic [3:0]  port;
      logic [15:0] fid;
   } act_t;

   typedef struct packed {
      logic [63:0] d;
      logic [7:0]  k;
      logic        l;
      logic [3:0]  dest;
   } beat_t;

   int    n_chk = 0;
   int    n_fail = 0;
   bit    mr_pat [4];
   act_t  aq[$];
   beat_t bq[$];
   beat_t oq[$];
   beat_t exp_q[$];
   int    acc_c[$], bin_c[$], trap_c[$];
   logic [15:0] trap_ids[$];
   int    first_mv, stall_bad, ar_bad, sr_bad;
   bit    fin;

   task automatic clear_log();
      aq.delete(); bq.delete(); oq.delete(); exp_q.delete();
      acc_c.delete(); bin_c.delete(); trap_c.delete(); trap_ids.delete();
      first_mv = -1; stall_bad = 0; ar_bad = 0; sr_bad = 0;
   endtask

   task automatic add_beat(input logic [63:0] d, input logic [7:0] k, input logic l, input logic [3:0] dest);
      bq.push_back(beat_t'{d, k, l, 4'd0});
      exp_q.push_back(beat_t'{d, k, l, dest});
   endtask

   // Cycle engine; starts and ends at a falling edge, samples 1 time unit after it.
   task automatic run(input int max, output bit done);
      bit          in_pkt;
      bit          prev_stall;
      logic [76:0] snap, prev_snap;
      bit          al, bl;
      in_pkt = 0; prev_stall = 0; prev_snap = '0; done = 0;
      for (int i = 0; i < max; i++) begin
         act_valid = (aq.size() > 0);
         {act_hit, act_drop, act_forward, act_trap, act_out_port, act_flow_id} = (aq.size() > 0) ? aq[0] : '0;
         s_tvalid = (bq.size() > 0);
         {s_tdata, s_tkeep, s_tlast} = (bq.size() > 0) ? bq[0][76:4] : '0;
         m_tready = mr_pat[i % 4];
         #1;
         snap = {m_tdata, m_tkeep, m_tlast, m_tdest};
         if (prev_stall && (!m_tvalid || snap !== prev_snap)) stall_bad++;
         prev_stall = m_tvalid && !m_tready;
         prev_snap  = snap;
         if (m_tvalid && first_mv < 0) first_mv = i;
         if (m_tvalid && m_tready) oq.push_back(beat_t'{m_tdata, m_tkeep, m_tlast, m_tdest});
         if (trap_valid) begin trap_c.push_back(i); trap_ids.push_back(trap_flow_id); end
         if (act_ready && in_pkt) ar_bad++;
         if (s_tready && !in_pkt) sr_bad++;
         al = act_valid && act_ready;
         bl = s_tvalid && s_tready;
         if (al) begin acc_c.push_back(i); void'(aq.pop_front()); in_pkt = 1; end
         if (bl) begin bin_c.push_back(i); if (s_tlast) in_pkt = 0; void'(bq.pop_front()); end
         @(negedge clk);
         if (aq.size() == 0 && bq.size() == 0 && !m_tvalid) begin done = 1; break; end
      end
      act_valid = 0; s_tvalid = 0; m_tready = 1;
   endtask

   task automatic check_beats(input string name);
      n_chk++;
      if (oq.size() !== exp_q.size()) begin
         n_fail++; $display("FAIL %s_count: got %0d beats, expected %0d", name, oq.size(), exp_q.size());
      end
      for (int k = 0; k < exp_q.size() && k < oq.size(); k++) begin
         n_chk++;
         if (oq[k] !== exp_q[k]) begin
            n_fail++; $display("FAIL %s_beat%0d: got %h, expected %h", name, k, oq[k], exp_q[k]);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1; act_valid = 0; act_hit = 0; act_drop = 0; act_forward = 0; act_trap = 0;
      act_out_port = 0; act_flow_id = 0; s_tdata = 0; s_tkeep = 0; s_tlast = 0; s_tvalid = 0; m_tready = 1;
      repeat (2) @(negedge clk);
      #1;
      n_chk++; if (act_ready !== 1'b0) begin n_fail++; $display("FAIL rst_act_ready: got %b expected 0", act_ready); end
      n_chk++; if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL rst_m_tvalid: got %b expected 0", m_tvalid); end
      n_chk++; if (trap_valid !== 1'b0) begin n_fail++; $display("FAIL rst_trap_valid: got %b expected 0", trap_valid); end
      n_chk++; if (s_tready !== 1'b0) begin n_fail++; $display("FAIL rst_s_tready: got %b expected 0", s_tready); end
      n_chk++; if ({m_tdata, m_tdest, trap_flow_id} !== 84'h0) begin n_fail++; $display("FAIL rst_outputs: got %h expected 0", {m_tdata, m_tdest, trap_flow_id}); end
      @(negedge clk); rst = 0;
      @(negedge clk); #1;
      n_chk++; if (act_ready !== 1'b1) begin n_fail++; $display("FAIL idle_act_ready: got %b expected 1", act_ready); end
      n_chk++; if (s_tready !== 1'b0) begin n_fail++; $display("FAIL idle_s_tready: got %b expected 0", s_tready); end
      @(negedge clk);
   endtask

   task automatic test_forward();
      clear_log();
      aq.push_back(act_t'{1'b1, 1'b0, 1'b1, 1'b0, 4'd5, 16'h0});
      for (int k = 0; k < 4; k++)
         add_beat(64'h1111_2222_0000_0000 + 64'(k), (k == 3) ? 8'h3F : 8'hFF, (k == 3), 4'd5);
      run(100, fin);
      n_chk++; if (!fin) begin n_fail++; $display("FAIL fwd_timeout: got 0 expected 1"); end
      check_beats("fwd");
      n_chk++; if (first_mv !== 2) begin n_fail++; $display("FAIL fwd_first_mvalid: got %0d expected 2", first_mv); end
      n_chk++; if (sr_bad !== 0) begin n_fail++; $display("FAIL fwd_idle_stall: got %0d expected 0", sr_bad); end
   endtask

   task automatic test_drop_priority();
      clear_log();
      aq.push_back(act_t'{1'b1, 1'b1, 1'b1, 1'b0, 4'd9, 16'h0});
      for (int k = 0; k < 3; k++) begin
         bq.push_back(beat_t'{64'hDEAD_0000_0000_0000 + 64'(k), 8'hFF, (k == 2), 4'd0});
      end
      run(100, fin);
      n_chk++; if (!fin) begin n_fail++; $display("FAIL drop_timeout: got 0 expected 1"); end
      n_chk++; if (oq.size() !== 0 || first_mv !== -1) begin n_fail++; $display("FAIL drop_mvalid: got %0d beats first %0d expected none", oq.size(), first_mv); end
      n_chk++; if (bin_c.size() !== 3 || bin_c[0] !== 1 || bin_c[2] !== 3) begin n_fail++; $display("FAIL drop_consume: got %0d beats expected 3 on cycles 1..3", bin_c.size()); end
      #1;
      n_chk++; if (act_ready !== 1'b1) begin n_fail++; $display("FAIL drop_back_idle: got %b expected 1", act_ready); end
      @(negedge clk);
   endtask

   task automatic test_trap_miss();
      clear_log();
      aq.push_back(act_t'{1'b1, 1'b0, 1'b1, 1'b1, 4'd3, 16'h0123});
      add_beat(64'hCAFE_0000_0000_0001, 8'hFF, 1'b0, 4'd3);
      add_beat(64'hCAFE_0000_0000_0002, 8'h01, 1'b1, 4'd3);
      run(100, fin);
      n_chk++; if (!fin) begin n_fail++; $display("FAIL trap_timeout: got 0 expected 1"); end
      n_chk++; if (trap_c.size() !== 1) begin n_fail++; $display("FAIL trap_pulses: got %0d expected 1", trap_c.size()); end
      n_chk++; if (trap_c.size() > 0 && trap_c[0] !== 1) begin n_fail++; $display("FAIL trap_cycle: got %0d expected 1", trap_c[0]); end
      n_chk++; if (trap_ids.size() > 0 && trap_ids[0] !== 16'h0123) begin n_fail++; $display("FAIL trap_flow_id: got %h expected 0123", trap_ids[0]); end
      check_beats("trap_fwd");
      clear_log();
      aq.push_back(act_t'{1'b0, 1'b0, 1'b1, 1'b1, 4'd7, 16'h0456});
      bq.push_back(beat_t'{64'h0505_0505_0505_0505, 8'hFF, 1'b0, 4'd0});
      bq.push_back(beat_t'{64'h0606_0606_0606_0606, 8'hFF, 1'b1, 4'd0});
      run(100, fin);
      n_chk++; if (!fin) begin n_fail++; $display("FAIL miss_timeout: got 0 expected 1"); end
      n_chk++; if (oq.size() !== 0) begin n_fail++; $display("FAIL miss_drop: got %0d beats expected 0", oq.size()); end
      n_chk++; if (trap_c.size() !== 0) begin n_fail++; $display("FAIL miss_no_trap: got %0d pulses expected 0", trap_c.size()); end
      n_chk++; if (trap_flow_id !== 16'h0123) begin n_fail++; $display("FAIL trap_id_held: got %h expected 0123", trap_flow_id); end
   endtask

   task automatic test_backpressure();
      clear_log();
      mr_pat = '{1'b1, 1'b0, 1'b0, 1'b1};
      aq.push_back(act_t'{1'b1, 1'b0, 1'b1, 1'b0, 4'd6, 16'h0});
      for (int k = 0; k < 8; k++)
         add_beat(64'hBEEF_0000_0000_0000 + 64'(k) * 64'h0101, (k == 7) ? 8'h0F : 8'hFF, (k == 7), 4'd6);
      run(200, fin);
      mr_pat = '{1'b1, 1'b1, 1'b1, 1'b1};
      n_chk++; if (!fin) begin n_fail++; $display("FAIL bp_timeout: got 0 expected 1"); end
      check_beats("bp");
      n_chk++; if (stall_bad !== 0) begin n_fail++; $display("FAIL bp_stable: got %0d changes expected 0", stall_bad); end
   endtask

   task automatic test_back_to_back();
      clear_log();
      aq.push_back(act_t'{1'b1, 1'b0, 1'b1, 1'b0, 4'd1, 16'h0});
      aq.push_back(act_t'{1'b1, 1'b1, 1'b0, 1'b0, 4'd8, 16'h0});
      aq.push_back(act_t'{1'b1, 1'b0, 1'b1, 1'b0, 4'd2, 16'h0});
      add_beat(64'h0000_0000_0000_00B1, 8'hFF, 1'b1, 4'd1);
      bq.push_back(beat_t'{64'h0000_0000_0000_00B2, 8'hFF, 1'b1, 4'd0});
      add_beat(64'h0000_0000_0000_00B3, 8'h80, 1'b1, 4'd2);
      run(100, fin);
      n_chk++; if (!fin) begin n_fail++; $display("FAIL b2b_timeout: got 0 expected 1"); end
      check_beats("b2b");
      n_chk++; if (acc_c.size() !== 3 || acc_c[1] !== 2 || acc_c[2] !== 4) begin n_fail++; $display("FAIL b2b_accept: got %0d accepts expected cycles 0,2,4", acc_c.size()); end
      n_chk++; if (ar_bad !== 0) begin n_fail++; $display("FAIL b2b_act_ready: got %0d busy-ready cycles expected 0", ar_bad); end
   endtask

`ifdef ACTION_EXEC_STATS_EN
   task automatic test_stats();
      n_chk++; if (fwd_cnt !== 32'd5) begin n_fail++; $display("FAIL stats_fwd: got %0d expected 5", fwd_cnt); end
      n_chk++; if (drop_cnt !== 32'd3) begin n_fail++; $display("FAIL stats_drop: got %0d expected 3", drop_cnt); end
      n_chk++; if (trap_cnt !== 32'd1) begin n_fail++; $display("FAIL stats_trap: got %0d expected 1", trap_cnt); end
   endtask
`endif

   task automatic test_reset_mid_packet();
      clear_log();
      aq.push_back(act_t'{1'b1, 1'b0, 1'b1, 1'b1, 4'd4, 16'h0BAD});
      for (int k = 0; k < 4; k++)
         bq.push_back(beat_t'{64'h7777_0000_0000_0000 + 64'(k), 8'hFF, (k == 3), 4'd0});
      run(3, fin);
      n_chk++; if (m_tvalid !== 1'b1 || m_tdata !== 64'h7777_0000_0000_0001) begin n_fail++; $display("FAIL mid_pre: got v=%b d=%h expected v=1 d=7777000000000001", m_tvalid, m_tdata); end
      rst = 1;
      #1;
      n_chk++; if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL mid_m_tvalid: got %b expected 0", m_tvalid); end
      n_chk++; if (trap_valid !== 1'b0) begin n_fail++; $display("FAIL mid_trap_valid: got %b expected 0", trap_valid); end
      n_chk++; if (act_ready !== 1'b0) begin n_fail++; $display("FAIL mid_act_ready_rst: got %b expected 0", act_ready); end
      @(negedge clk); rst = 0;
      @(negedge clk); #1;
      n_chk++; if (act_ready !== 1'b1) begin n_fail++; $display("FAIL mid_act_ready: got %b expected 1", act_ready); end
      n_chk++; if (s_tready !== 1'b0) begin n_fail++; $display("FAIL mid_s_tready: got %b expected 0", s_tready); end
`ifdef ACTION_EXEC_STATS_EN
      n_chk++; if ({fwd_cnt, drop_cnt, trap_cnt} !== 96'h0) begin n_fail++; $display("FAIL mid_stats: got %h expected 0", {fwd_cnt, drop_cnt, trap_cnt}); end
`endif
      @(negedge clk);
   endtask

   initial begin
      mr_pat = '{1'b1, 1'b1, 1'b1, 1'b1};
      test_reset();
      test_forward();
      test_drop_priority();
      test_trap_miss();
      test_backpressure();
      test_back_to_back();
`ifdef ACTION_EXEC_STATS_EN
      test_stats();
`endif
      test_reset_mid_packet();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
